// File: rtl/vision_pkg.sv
// Shared types for the vision pipeline: coordinate widths, signed window offsets,
// patch-fetch FSM states and the tag that travels alongside each frame-buffer read.
package vision_pkg;

    function automatic int coord_width(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    localparam int XW       = coord_width(640);
    localparam int YW       = coord_width(480);
    localparam int OFFSET_W = 8;

    typedef logic signed [OFFSET_W-1:0] offset_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic issued;
        logic border;
        logic last;
    } patch_tag_t;

endpackage

// File: rtl/coord_clamp.sv
// Adds a signed window offset to an unsigned coordinate and saturates the
// result to [0, MAX], flagging whether saturation took place.
module coord_clamp
    import vision_pkg::*;
#(
    parameter int W   = 10,
    parameter int MAX = 639
) (
    input  logic [W-1:0] base,
    input  offset_t      offset,
    output logic [W-1:0] coord,
    output logic         border
);

    // Two guard bits: base can sit anywhere up to 2^W-1, so base+offset must
    // never wrap even for keypoints that lie outside the image.
    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

    logic signed [SW-1:0] sum;

    assign sum = $signed({2'b00, base}) + SW'(offset);

    always_comb begin
        coord  = sum[W-1:0];
        border = 1'b0;
        if (sum[SW-1]) begin
            coord  = '0;
            border = 1'b1;
        end else if (sum > MAX_S) begin
            coord  = W'(MAX);
            border = 1'b1;
        end
    end

endmodule

// File: rtl/keypoint_patch_fetcher.sv
// Sweeps a PATCH_SIZE x PATCH_SIZE window around one keypoint through the frame
// buffer's random-read port and re-aligns the returned pixels into a row-major stream.
module keypoint_patch_fetcher
    import vision_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int PATCH_SIZE   = 7,
    parameter int READ_LATENCY = 2,
    localparam int CXW = coord_width(IMAGE_WIDTH),
    localparam int CYW = coord_width(IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kp_valid,
    output logic                  kp_ready,
    input  logic [CXW-1:0]        kp_x,
    input  logic [CYW-1:0]        kp_y,
    output logic                  fb_read_enable,
    output logic [CXW-1:0]        fb_read_x,
    output logic [CYW-1:0]        fb_read_y,
    input  logic [DATA_WIDTH-1:0] fb_read_pixel,
    output logic                  patch_valid,
    output logic [DATA_WIDTH-1:0] patch_pixel,
    output logic                  patch_border,
    output logic                  patch_last
);

    localparam int      R          = PATCH_SIZE / 2;
    localparam offset_t R_POS      = offset_t'(R);
    localparam offset_t R_NEG      = offset_t'(-R);
    localparam int      DCW        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(READ_LATENCY - 1);

    fetch_state_e   state_reg;
    fetch_state_e   state_next;
    offset_t        dx_reg;
    offset_t        dy_reg;
    offset_t        dx_next;
    offset_t        dy_next;
    logic [CXW-1:0] kp_x_reg;
    logic [CYW-1:0] kp_y_reg;
    logic [CXW-1:0] base_x;
    logic [CYW-1:0] base_y;
    logic [CXW-1:0] clamp_x;
    logic [CYW-1:0] clamp_y;
    logic           border_x;
    logic           border_y;
    logic [DCW-1:0] drain_cnt_reg;
    logic           load;
    logic           advance;
    logic           last_addr;
    logic           last_next;
    patch_tag_t     issue_tag_reg;
    patch_tag_t     patch_tag;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (kp_valid)                       state_next = ISSUE;
            ISSUE:   if (last_addr)                      state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg == DRAIN_LAST)    state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        kp_ready = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        case (state_reg)
            IDLE: begin
                kp_ready = 1'b1;
                load     = kp_valid;
            end
            ISSUE:   advance = !last_addr;
            default: ;
        endcase
    end

    // Window walk: the clamps look at the offset for the *next* address so the
    // address register is loaded in the same cycle the keypoint is accepted.
    assign last_addr = (dx_reg == R_POS) && (dy_reg == R_POS);

    always_comb begin
        dx_next = dx_reg;
        dy_next = dy_reg;
        if (load) begin
            dx_next = R_NEG;
            dy_next = R_NEG;
        end else if (dx_reg == R_POS) begin
            dx_next = R_NEG;
            dy_next = dy_reg + offset_t'(1);
        end else begin
            dx_next = dx_reg + offset_t'(1);
        end
    end

    assign last_next = (dx_next == R_POS) && (dy_next == R_POS);
    assign base_x    = load ? kp_x : kp_x_reg;
    assign base_y    = load ? kp_y : kp_y_reg;

    coord_clamp #(
        .W   (CXW),
        .MAX (IMAGE_WIDTH - 1)
    ) u_clamp_x (
        .base   (base_x),
        .offset (dx_next),
        .coord  (clamp_x),
        .border (border_x)
    );

    coord_clamp #(
        .W   (CYW),
        .MAX (IMAGE_HEIGHT - 1)
    ) u_clamp_y (
        .base   (base_y),
        .offset (dy_next),
        .coord  (clamp_y),
        .border (border_y)
    );

    // ---------------- Address / tag issue ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            kp_x_reg       <= '0;
            kp_y_reg       <= '0;
            dx_reg         <= '0;
            dy_reg         <= '0;
            drain_cnt_reg  <= '0;
            fb_read_enable <= 1'b0;
            fb_read_x      <= '0;
            fb_read_y      <= '0;
            issue_tag_reg  <= '0;
        end else begin
            // Enable stays up through DRAIN (address held) so in-flight reads complete.
            fb_read_enable <= (state_next != IDLE);
            issue_tag_reg  <= '0;
            if (load) begin
                kp_x_reg <= kp_x;
                kp_y_reg <= kp_y;
            end
            if (load || advance) begin
                dx_reg        <= dx_next;
                dy_reg        <= dy_next;
                fb_read_x     <= clamp_x;
                fb_read_y     <= clamp_y;
                issue_tag_reg <= '{issued: 1'b1, border: (border_x | border_y), last: last_next};
            end
            if (state_reg == DRAIN) begin
                drain_cnt_reg <= drain_cnt_reg + DCW'(1);
            end else begin
                drain_cnt_reg <= '0;
            end
        end
    end

    // ---------------- Latency delay line ----------------
    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_delay
            patch_tag_t tag_reg;
            patch_tag_t tag_in;
            if (gi == 0) begin : g_head
                assign tag_in = issue_tag_reg;
            end else begin : g_body
                assign tag_in = g_delay[gi-1].tag_reg;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_reg <= '0;
                end else begin
                    tag_reg <= tag_in;
                end
            end
        end
    endgenerate

    assign patch_tag    = g_delay[READ_LATENCY-1].tag_reg;
    assign patch_valid  = patch_tag.issued;
    assign patch_border = patch_tag.border;
    assign patch_last   = patch_tag.last;
    assign patch_pixel  = patch_tag.issued ? fb_read_pixel : '0;

endmodule

// File: tb/tb_keypoint_patch_fetcher.sv
// Bench for keypoint_patch_fetcher: 2-cycle frame-buffer model with pixel(x,y)=(x+3y)&FF,
// a window-level reference model, and per-scenario tasks.
module tb_keypoint_patch_fetcher;

    localparam int XW    = vision_pkg::XW;
    localparam int YW    = vision_pkg::YW;
    localparam int N     = 7;
    localparam int BEATS = N * N;
    localparam int WMAX  = 639;
    localparam int HMAX  = 479;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          kp_valid = 1'b0;
    logic          kp_ready;
    logic [XW-1:0] kp_x = '0;
    logic [YW-1:0] kp_y = '0;
    logic          fb_read_enable;
    logic [XW-1:0] fb_read_x;
    logic [YW-1:0] fb_read_y;
    logic [7:0]    fb_read_pixel = 8'h00;
    logic [7:0]    fb_pipe = 8'h00;
    logic          patch_valid;
    logic [7:0]    patch_pixel;
    logic          patch_border;
    logic          patch_last;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [7:0] pix;
        logic       border;
        logic       last;
        int         cyc;
    } beat_t;

    beat_t obs_q[$];
    beat_t exp_q[$];
    int    acc_q[$];
    beat_t mon_b;

    always #5 clk = ~clk;

    keypoint_patch_fetcher dut (
        .clk            (clk),
        .rst            (rst),
        .kp_valid       (kp_valid),
        .kp_ready       (kp_ready),
        .kp_x           (kp_x),
        .kp_y           (kp_y),
        .fb_read_enable (fb_read_enable),
        .fb_read_x      (fb_read_x),
        .fb_read_y      (fb_read_y),
        .fb_read_pixel  (fb_read_pixel),
        .patch_valid    (patch_valid),
        .patch_pixel    (patch_pixel),
        .patch_border   (patch_border),
        .patch_last     (patch_last)
    );

    function automatic logic [7:0] pix_at(input int x, input int y);
        return 8'((x + 3 * y) & 255);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
    end

    // Frame buffer: two-cycle read latency.
    always @(posedge clk) begin
        fb_pipe       <= fb_read_enable ? pix_at(int'(fb_read_x), int'(fb_read_y)) : 8'h00;
        fb_read_pixel <= fb_pipe;
    end

    // Monitor: records accepting edges and every emitted beat with its edge index.
    always @(negedge clk) begin
        if (!rst && kp_valid && kp_ready) acc_q.push_back(cyc + 1);
        if (patch_valid) begin
            mon_b.pix    = patch_pixel;
            mon_b.border = patch_border;
            mon_b.last   = patch_last;
            mon_b.cyc    = cyc;
            obs_q.push_back(mon_b);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference: window row-major, per-axis clamp, beat i two edges after address i.
    task automatic add_expect(input int x, input int y, input int acc);
        for (int i = 0; i < BEATS; i++) begin
            int px;
            int py;
            bit bx;
            bit by;
            beat_t b;
            px = x + (i % N) - N / 2;
            py = y + (i / N) - N / 2;
            bx = (px < 0) || (px > WMAX);
            by = (py < 0) || (py > HMAX);
            px = (px < 0) ? 0 : ((px > WMAX) ? WMAX : px);
            py = (py < 0) ? 0 : ((py > HMAX) ? HMAX : py);
            b.pix    = pix_at(px, py);
            b.border = bx | by;
            b.last   = (i == BEATS - 1);
            b.cyc    = acc + 2 + i;
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_queues();
        obs_q.delete();
        exp_q.delete();
        acc_q.delete();
    endtask

    // Offers a keypoint and waits (bounded) for the handshake edge.
    task automatic offer_kp(input int x, input int y, input bit hold);
        int  n0;
        bit  ok;
        n0 = acc_q.size();
        ok = 1'b0;
        kp_x = XW'(x);
        kp_y = YW'(y);
        kp_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (acc_q.size() > n0) ok = 1'b1;
        end
        if (!hold) kp_valid = 1'b0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL accept_timeout: kp(%0d,%0d) got no handshake in 200 cycles, expected one", x, y);
            kp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (kp_ready !== 1'b1)       begin mismatched++; $display("FAIL reset_kp_ready: got %b expected 1", kp_ready); end
        compared++; if (fb_read_enable !== 1'b0) begin mismatched++; $display("FAIL reset_fb_en: got %b expected 0", fb_read_enable); end
        compared++; if (fb_read_x !== '0)        begin mismatched++; $display("FAIL reset_fb_x: got %0d expected 0", fb_read_x); end
        compared++; if (fb_read_y !== '0)        begin mismatched++; $display("FAIL reset_fb_y: got %0d expected 0", fb_read_y); end
        compared++; if (patch_valid !== 1'b0)    begin mismatched++; $display("FAIL reset_valid: got %b expected 0", patch_valid); end
        compared++; if (patch_border !== 1'b0)   begin mismatched++; $display("FAIL reset_border: got %b expected 0", patch_border); end
        compared++; if (patch_last !== 1'b0)     begin mismatched++; $display("FAIL reset_last: got %b expected 0", patch_last); end
        compared++; if (patch_pixel !== 8'h00)   begin mismatched++; $display("FAIL reset_pixel: got %02h expected 00", patch_pixel); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("reset: checks done");
    endtask

    task automatic test_center();
        clear_queues();
        offer_kp(320, 240, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        if (acc_q.size() > 0) add_expect(320, 240, acc_q[0]);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL center_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].border !== exp_q[i].border ||
                obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != exp_q[i].cyc) begin
                mismatched++;
                $display("FAIL center_beat[%0d]: got pix=%02h b=%b l=%b cyc=%0d expected pix=%02h b=%b l=%b cyc=%0d",
                         i, obs_q[i].pix, obs_q[i].border, obs_q[i].last, obs_q[i].cyc,
                         exp_q[i].pix, exp_q[i].border, exp_q[i].last, exp_q[i].cyc);
            end
        end
        compared++;
        if (obs_q.size() == 0 || obs_q[0].pix !== 8'h04) begin
            mismatched++;
            $display("FAIL center_first: got %02h expected 04", (obs_q.size() > 0) ? obs_q[0].pix : 8'hxx);
        end
        $display("center kp(320,240): %0d beats observed", obs_q.size());
    endtask

    task automatic test_borders();
        int kx[4];
        int ky[4];
        kx = '{0, 639, 0, 639};
        ky = '{0, 479, 479, 0};
        for (int k = 0; k < 4; k++) begin
            clear_queues();
            offer_kp(kx[k], ky[k], 1'b0);
            repeat (60) @(posedge clk);
            #1;
            if (acc_q.size() > 0) add_expect(kx[k], ky[k], acc_q[0]);
            compared++;
            if (obs_q.size() != exp_q.size()) begin
                mismatched++;
                $display("FAIL border_count kp(%0d,%0d): got %0d beats expected %0d", kx[k], ky[k], obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                compared++;
                if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].border !== exp_q[i].border ||
                    obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != exp_q[i].cyc) begin
                    mismatched++;
                    $display("FAIL border_beat kp(%0d,%0d)[%0d]: got pix=%02h b=%b l=%b cyc=%0d expected pix=%02h b=%b l=%b cyc=%0d",
                             kx[k], ky[k], i, obs_q[i].pix, obs_q[i].border, obs_q[i].last, obs_q[i].cyc,
                             exp_q[i].pix, exp_q[i].border, exp_q[i].last, exp_q[i].cyc);
                end
            end
            if (k == 0) begin
                compared++;
                if (obs_q.size() < BEATS || obs_q[24].pix !== 8'h00 || obs_q[24].border !== 1'b0) begin
                    mismatched++;
                    $display("FAIL origin_centre: got %0d beats / beat24 wrong, expected pix=00 border=0", obs_q.size());
                end
            end
            if (k == 1) begin
                compared++;
                if (obs_q.size() < BEATS || obs_q[48].pix !== pix_at(639, 479) ||
                    obs_q[48].border !== 1'b1 || obs_q[48].last !== 1'b1) begin
                    mismatched++;
                    $display("FAIL far_corner_last: got %0d beats / beat48 wrong, expected pix=%02h border=1 last=1",
                             obs_q.size(), pix_at(639, 479));
                end
            end
            $display("border kp(%0d,%0d): %0d beats observed", kx[k], ky[k], obs_q.size());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int x;
            int y;
            x = (k < 3) ? $urandom_range(0, 639) : $urandom_range(600, 1023);
            y = (k < 3) ? $urandom_range(0, 479) : $urandom_range(440, 511);
            clear_queues();
            offer_kp(x, y, 1'b0);
            repeat (60) @(posedge clk);
            #1;
            if (acc_q.size() > 0) add_expect(x, y, acc_q[0]);
            compared++;
            if (obs_q.size() != exp_q.size()) begin
                mismatched++;
                $display("FAIL random_count kp(%0d,%0d): got %0d beats expected %0d", x, y, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                compared++;
                if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].border !== exp_q[i].border ||
                    obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != exp_q[i].cyc) begin
                    mismatched++;
                    $display("FAIL random_beat kp(%0d,%0d)[%0d]: got pix=%02h b=%b l=%b cyc=%0d expected pix=%02h b=%b l=%b cyc=%0d",
                             x, y, i, obs_q[i].pix, obs_q[i].border, obs_q[i].last, obs_q[i].cyc,
                             exp_q[i].pix, exp_q[i].border, exp_q[i].last, exp_q[i].cyc);
                end
            end
            $display("random kp(%0d,%0d): %0d beats observed", x, y, obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ax;
        int ay;
        int bx;
        int by;
        ax = $urandom_range(0, 639);
        ay = $urandom_range(0, 479);
        bx = $urandom_range(0, 639);
        by = $urandom_range(0, 479);
        clear_queues();
        offer_kp(ax, ay, 1'b1);
        offer_kp(bx, by, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        compared++;
        if (acc_q.size() != 2 || (acc_q[1] - acc_q[0]) != BEATS + 3) begin
            mismatched++;
            $display("FAIL b2b_accept_gap: got %0d handshakes gap=%0d expected 2 handshakes gap=%0d",
                     acc_q.size(), (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1, BEATS + 3);
        end
        if (acc_q.size() > 0) add_expect(ax, ay, acc_q[0]);
        if (acc_q.size() > 1) add_expect(bx, by, acc_q[1]);
        compared++;
        if (obs_q.size() != 2 * BEATS) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d beats expected %0d", obs_q.size(), 2 * BEATS);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].border !== exp_q[i].border ||
                obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != exp_q[i].cyc) begin
                mismatched++;
                $display("FAIL b2b_beat[%0d]: got pix=%02h b=%b l=%b cyc=%0d expected pix=%02h b=%b l=%b cyc=%0d",
                         i, obs_q[i].pix, obs_q[i].border, obs_q[i].last, obs_q[i].cyc,
                         exp_q[i].pix, exp_q[i].border, exp_q[i].last, exp_q[i].cyc);
            end
        end
        $display("back_to_back kp(%0d,%0d)+kp(%0d,%0d): %0d beats observed", ax, ay, bx, by, obs_q.size());
    endtask

    task automatic test_ignore_busy();
        clear_queues();
        offer_kp(200, 50, 1'b0);
        for (int t = 0; t < 36; t++) begin
            @(posedge clk);
            #1;
            kp_valid = 1'($urandom_range(0, 1));
            kp_x     = XW'($urandom_range(0, 639));
            kp_y     = YW'($urandom_range(0, 479));
        end
        kp_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        compared++;
        if (acc_q.size() != 1) begin
            mismatched++;
            $display("FAIL busy_accepts: got %0d handshakes expected 1", acc_q.size());
        end
        if (acc_q.size() > 0) add_expect(200, 50, acc_q[0]);
        compared++;
        if (obs_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL busy_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            compared++;
            if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].border !== exp_q[i].border ||
                obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != exp_q[i].cyc) begin
                mismatched++;
                $display("FAIL busy_beat[%0d]: got pix=%02h b=%b l=%b cyc=%0d expected pix=%02h b=%b l=%b cyc=%0d",
                         i, obs_q[i].pix, obs_q[i].border, obs_q[i].last, obs_q[i].cyc,
                         exp_q[i].pix, exp_q[i].border, exp_q[i].last, exp_q[i].cyc);
            end
        end
        $display("ignore_busy kp(200,50): %0d handshakes, %0d beats observed", acc_q.size(), obs_q.size());
    endtask

    task automatic test_reset_mid();
        int a;
        int late;
        clear_queues();
        offer_kp(100, 100, 1'b0);
        a = (acc_q.size() > 0) ? acc_q[0] : cyc;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        compared++; if (kp_ready !== 1'b1)       begin mismatched++; $display("FAIL midrst_kp_ready: got %b expected 1", kp_ready); end
        compared++; if (fb_read_enable !== 1'b0) begin mismatched++; $display("FAIL midrst_fb_en: got %b expected 0", fb_read_enable); end
        compared++; if (patch_valid !== 1'b0)    begin mismatched++; $display("FAIL midrst_valid: got %b expected 0", patch_valid); end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        late = 0;
        foreach (obs_q[i]) if (obs_q[i].cyc >= a + 20) late++;
        compared++;
        if (late != 0) begin
            mismatched++;
            $display("FAIL midrst_late_beats: got %0d beats after reset expected 0", late);
        end
        compared++;
        if (obs_q.size() != 18) begin
            mismatched++;
            $display("FAIL midrst_pre_beats: got %0d beats before reset expected 18", obs_q.size());
        end
        $display("reset_mid kp(100,100): %0d beats before abort", obs_q.size());
    endtask

    initial begin
        test_reset();
        test_center();
        test_borders();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
